// File: rtl/dsp_pkg.sv
// Shared DSP datapath definitions: opmode bit positions and a signed range
// check used by the post-adder and other datapath blocks.
package dsp_pkg;

  localparam int OPM_PRESUB  = 0;
  localparam int OPM_POSTSUB = 1;
  localparam int OPM_ACC     = 2;
  localparam int OPM_PREBYP  = 3;

  // Widest intermediate the range check accepts; callers sign-extend into it.
  localparam int RANGE_W = 128;

  // True when v is representable as a signed value of the given width, i.e.
  // every bit above the target sign bit is a copy of that sign bit.
  function automatic logic fits_signed(input logic signed [RANGE_W-1:0] v,
                                       input int width);
    logic signed [RANGE_W-1:0] hi;
    hi = v >>> (width - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/dsp_mac_slice_if.sv
// Operand/result bundle for one MAC slice channel; the producer drives the
// master side and the slice sits on the slave side.
interface dsp_mac_slice_if #(
  parameter int A_W = 18,
  parameter int B_W = 18,
  parameter int C_W = 48,
  parameter int P_W = 48
);
  logic                  ce;
  logic                  in_valid;
  logic signed [A_W-1:0] A;
  logic signed [B_W-1:0] B;
  logic signed [B_W-1:0] D;
  logic signed [C_W-1:0] C;
  logic [3:0]            opmode;
  logic                  clr_acc;
  logic                  out_valid;
  logic signed [P_W-1:0] P;
  logic                  ovf;

  modport master (
    output ce, in_valid, A, B, D, C, opmode, clr_acc,
    input  out_valid, P, ovf
  );

  modport slave (
    input  ce, in_valid, A, B, D, C, opmode, clr_acc,
    output out_valid, P, ovf
  );
endinterface

// File: rtl/dsp_sat_add.sv
// Signed post-adder X +/- M computed one bit wider than either operand, with
// overflow flag against P_W and optional clamping.
module dsp_sat_add
  import dsp_pkg::*;
#(
  parameter int P_W      = 48,
  parameter int M_W      = 37,
  parameter bit SATURATE = 1'b0
) (
  input  logic signed [P_W-1:0] x,
  input  logic signed [M_W-1:0] m,
  input  logic                  sub,
  output logic signed [P_W-1:0] r,
  output logic                  ovf
);

  localparam int R_W = ((P_W > M_W) ? P_W : M_W) + 1;
  localparam logic signed [P_W-1:0] P_MAX = {1'b0, {(P_W-1){1'b1}}};
  localparam logic signed [P_W-1:0] P_MIN = {1'b1, {(P_W-1){1'b0}}};

  logic signed [R_W-1:0] sum;

  always_comb begin
    sum = sub ? (R_W'(x) - R_W'(m)) : (R_W'(x) + R_W'(m));
    ovf = !fits_signed(RANGE_W'(sum), P_W);
    if (ovf && SATURATE) r = sum[R_W-1] ? P_MIN : P_MAX;
    else                 r = sum[P_W-1:0];
  end

endmodule

// File: rtl/dsp_mac_slice.sv
// Four-stage pre-add / multiply / post-add slice with per-beat opmode, valid
// tracking, clock enable, accumulator mode and overflow detection.
module dsp_mac_slice
  import dsp_pkg::*;
#(
  parameter int A_W      = 18,
  parameter int B_W      = 18,
  parameter int C_W      = 48,
  parameter int P_W      = 48,
  parameter bit SATURATE = 1'b0
) (
  input logic            clk,
  input logic            rst_n,
  dsp_mac_slice_if.slave bus
);

  localparam int PRE_W = B_W + 1;
  localparam int M_W   = A_W + B_W + 1;

  typedef struct packed {
    logic                  v;
    logic [3:0]            op;
    logic signed [A_W-1:0] a;
    logic signed [B_W-1:0] b;
    logic signed [B_W-1:0] d;
    logic signed [C_W-1:0] c;
  } s1_t;

  typedef struct packed {
    logic                    v;
    logic                    acc;
    logic                    post_sub;
    logic signed [A_W-1:0]   a;
    logic signed [PRE_W-1:0] pre;
    logic signed [C_W-1:0]   c;
  } s2_t;

  typedef struct packed {
    logic                  v;
    logic                  acc;
    logic                  post_sub;
    logic signed [M_W-1:0] m;
    logic signed [C_W-1:0] c;
  } s3_t;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  s3_t s3_q, s3_d;
  logic signed [P_W-1:0] p_q, p_d;
  logic                  ovf_q, ovf_d;
  logic                  out_valid_q, out_valid_d;

  logic signed [P_W-1:0] acc_x;
  logic signed [P_W-1:0] sum_p;
  logic                  sum_ovf;

  // A clear landing on an accumulate beat replaces the old P with zero.
  always_comb begin
    if (s3_q.acc) acc_x = bus.clr_acc ? '0 : p_q;
    else          acc_x = P_W'($signed(s3_q.c));
  end

  dsp_sat_add #(
    .P_W      (P_W),
    .M_W      (M_W),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .x   (acc_x),
    .m   (s3_q.m),
    .sub (s3_q.post_sub),
    .r   (sum_p),
    .ovf (sum_ovf)
  );

  // NOTE: every *_d starts from its *_q, so no path leaves a signal unassigned
  // and no latch is inferred; with ce=0 that default is also the hold.
  always_comb begin
    s1_d        = s1_q;
    s2_d        = s2_q;
    s3_d        = s3_q;
    p_d         = p_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    if (bus.ce) begin
      s1_d.v  = bus.in_valid;
      s1_d.op = bus.opmode;
      s1_d.a  = bus.A;
      s1_d.b  = bus.B;
      s1_d.d  = bus.D;
      s1_d.c  = bus.C;

      s2_d.v        = s1_q.v;
      s2_d.acc      = s1_q.op[OPM_ACC];
      s2_d.post_sub = s1_q.op[OPM_POSTSUB];
      s2_d.a        = s1_q.a;
      s2_d.c        = s1_q.c;
      if (s1_q.op[OPM_PREBYP])      s2_d.pre = PRE_W'($signed(s1_q.b));
      else if (s1_q.op[OPM_PRESUB]) s2_d.pre = PRE_W'($signed(s1_q.b)) - PRE_W'($signed(s1_q.d));
      else                          s2_d.pre = PRE_W'($signed(s1_q.b)) + PRE_W'($signed(s1_q.d));

      s3_d.v        = s2_q.v;
      s3_d.acc      = s2_q.acc;
      s3_d.post_sub = s2_q.post_sub;
      s3_d.c        = s2_q.c;
      s3_d.m        = M_W'($signed(s2_q.a)) * M_W'($signed(s2_q.pre));

      out_valid_d = s3_q.v;
      if (s3_q.v) begin
        p_d   = sum_p;
        ovf_d = sum_ovf;
      end else if (bus.clr_acc) begin
        p_d   = '0;
        ovf_d = 1'b0;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments, and the asynchronous
  // reset clears every stage (data included) so no stale beat survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      p_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      p_q         <= p_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.P         = p_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_dsp_mac_slice.sv
// Self-checking bench for dsp_mac_slice: directed scenarios plus randomized
// traffic against an arithmetic reference model of the slice.
module tb_dsp_mac_slice;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dsp_mac_slice_if                              bus   ();
  dsp_mac_slice_if #(.C_W(40), .P_W(40))        bus_s ();
  dsp_mac_slice_if #(.C_W(40), .P_W(40))        bus_w ();

  dsp_mac_slice u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  dsp_mac_slice #(.C_W(40), .P_W(40), .SATURATE(1'b1)) u_sat40 (
    .clk(clk), .rst_n(rst_n), .bus(bus_s));

  dsp_mac_slice #(.C_W(40), .P_W(40), .SATURATE(1'b0)) u_wrap40 (
    .clk(clk), .rst_n(rst_n), .bus(bus_w));

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit       v;
    longint   a, b, d, c;
    bit [3:0] op;
  } beat_t;

  // Reference model: beats still in flight, plus the visible result state.
  beat_t  hist[$];
  longint mp;
  bit     movf;
  bit     mvalid;

  function automatic longint wrap(input longint r, input int pw);
    return (r <<< (64 - pw)) >>> (64 - pw);
  endfunction

  function automatic bit out_of_range(input longint r, input int pw);
    longint lim;
    lim = longint'(1) <<< (pw - 1);
    return (r >= lim) || (r < -lim);
  endfunction

  task automatic model_reset();
    beat_t empty;
    empty = '{v: 1'b0, a: 0, b: 0, d: 0, c: 0, op: 4'd0};
    mp = 0; movf = 1'b0; mvalid = 1'b0;
    hist.delete();
    repeat (3) hist.push_back(empty);
  endtask

  // One enabled clock: a beat issued 3 enabled edges ago lands in P now,
  // and the clear applies to this same edge.
  task automatic model_edge(input bit clr, input beat_t cur);
    beat_t  s;
    longint pre, m, x, r;
    hist.push_back(cur);
    s = hist.pop_front();
    if (s.v) begin
      pre = s.op[3] ? s.b : (s.op[0] ? s.b - s.d : s.b + s.d);
      m   = s.a * pre;
      x   = s.op[2] ? (clr ? 0 : mp) : s.c;
      r   = s.op[1] ? x - m : x + m;
      movf   = out_of_range(r, 48);
      mp     = wrap(r, 48);
      mvalid = 1'b1;
    end else begin
      mvalid = 1'b0;
      if (clr) begin
        mp = 0; movf = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic signed [47:0] ep;
    ep = mp[47:0];
    checks++;
    if (bus.out_valid !== mvalid) begin
      errors++;
      $display("FAIL %s out_valid: got %0b want %0b", tag, bus.out_valid, mvalid);
    end
    checks++;
    if (bus.ovf !== movf) begin
      errors++;
      $display("FAIL %s ovf: got %0b want %0b", tag, bus.ovf, movf);
    end
    checks++;
    if (bus.P !== ep) begin
      errors++;
      $display("FAIL %s P: got %0d want %0d", tag, bus.P, ep);
    end
  endtask

  // Drive one cycle of main-bus stimulus (inputs change while clk is low),
  // advance the model on the rising edge, compare on the falling edge.
  task automatic step(input bit ce_i, input bit v, input longint a, input longint b,
                      input longint d, input longint c, input bit [3:0] op,
                      input bit clr, input string tag);
    beat_t cur;
    bus.ce = ce_i; bus.in_valid = v; bus.opmode = op; bus.clr_acc = clr;
    bus.A = a[17:0]; bus.B = b[17:0]; bus.D = d[17:0]; bus.C = c[47:0];
    cur.v = v; cur.op = op;
    cur.a = bus.A; cur.b = bus.B; cur.d = bus.D; cur.c = bus.C;
    @(posedge clk);
    if (rst_n && ce_i) model_edge(clr, cur);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) step(1'b1, 1'b0, 0, 0, 0, 0, 4'd0, 1'b0, tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.P !== '0 || bus.ovf !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got P=%0d ovf=%0b ov=%0b want 0/0/0",
               bus.P, bus.ovf, bus.out_valid);
    end
    model_reset();
    rst_n = 1'b1;
    idle(2, "post_reset");
  endtask

  task automatic test_basic();
    step(1'b1, 1'b1, 3, 5, 2, 10, 4'b0000, 1'b0, "basic_issue");
    idle(3, "basic_wait");
    checks++;
    if (bus.out_valid !== 1'b1 || bus.P !== 48'sd31 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got ov=%0b P=%0d ovf=%0b want 1/31/0",
               bus.out_valid, bus.P, bus.ovf);
    end
    idle(1, "basic_drain");
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b1, 3, 5, 7, 10, 4'b0011, 1'b0, "b2b_issue0");
    step(1'b1, 1'b1, -4, 6, 99, 0, 4'b1000, 1'b0, "b2b_issue1");
    idle(2, "b2b_wait");
    // pre = 5-7 = -2, M = -6, post-sub X - M = 10 - (-6)
    checks++;
    if (bus.out_valid !== 1'b1 || bus.P !== 48'sd16) begin
      errors++;
      $display("FAIL b2b_first: got ov=%0b P=%0d want 1/16", bus.out_valid, bus.P);
    end
    idle(1, "b2b_next");
    checks++;
    if (bus.out_valid !== 1'b1 || bus.P !== -48'sd24) begin
      errors++;
      $display("FAIL b2b_second: got ov=%0b P=%0d want 1/-24", bus.out_valid, bus.P);
    end
    idle(1, "b2b_drain");
  endtask

  task automatic test_accumulate();
    step(1'b1, 1'b0, 0, 0, 0, 0, 4'b0000, 1'b1, "acc_clear");
    checks++;
    if (bus.P !== '0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL acc_clear_state: got P=%0d ov=%0b want 0/0", bus.P, bus.out_valid);
    end
    repeat (4) step(1'b1, 1'b1, 2, 3, 0, 0, 4'b0100, 1'b0, "acc_beat");
    idle(3, "acc_wait");
    checks++;
    if (bus.P !== 48'sd24) begin
      errors++;
      $display("FAIL acc_sum: got %0d want 24", bus.P);
    end
    repeat (4) step(1'b1, 1'b1, 2, 3, 0, 0, 4'b0100, 1'b0, "acc2_beat");
    idle(2, "acc2_wait");
    step(1'b1, 1'b0, 0, 0, 0, 0, 4'b0000, 1'b1, "acc2_clr_hit");
    checks++;
    if (bus.P !== 48'sd6 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL acc_clear_on_beat: got P=%0d ov=%0b want 6/1", bus.P, bus.out_valid);
    end
    idle(1, "acc2_drain");
  endtask

  task automatic test_ce_toggle();
    longint a[3], b[3], d[3], c[3], pre, exp_r[3];
    bit [3:0] op[3];
    longint got[$];
    logic signed [47:0] e48;
    for (int i = 0; i < 3; i++) begin
      a[i] = $signed(18'($urandom)); b[i] = $signed(18'($urandom));
      d[i] = $signed(18'($urandom)); c[i] = $signed(32'($urandom));
      op[i] = 4'($urandom) & 4'b1011;
      pre = op[i][3] ? b[i] : (op[i][0] ? b[i] - d[i] : b[i] + d[i]);
      exp_r[i] = op[i][1] ? c[i] - a[i] * pre : c[i] + a[i] * pre;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, a[i], b[i], d[i], c[i], op[i], 1'b0, "ce_issue");
      if (bus.out_valid) got.push_back(bus.P);
      step(1'b0, 1'b1, 77, 77, 77, 77, 4'b0100, 1'b1, "ce_frozen");
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 0, 0, 0, 0, 4'd0, 1'b0, "ce_drain_on");
      if (bus.out_valid) got.push_back(bus.P);
      step(1'b0, 1'b0, 0, 0, 0, 0, 4'd0, 1'b1, "ce_drain_off");
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL ce_result_count: got %0d want 3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      e48 = exp_r[i][47:0];
      checks++;
      if (got[i] != longint'(e48)) begin
        errors++;
        $display("FAIL ce_result[%0d]: got %0d want %0d", i, got[i], e48);
      end
    end
  endtask

  task automatic run40(input longint c, input bit [3:0] op, input longint exp_s,
                       input longint exp_w, input bit exp_ovf, input string tag);
    logic signed [39:0] es, ew;
    es = exp_s[39:0]; ew = exp_w[39:0];
    bus_s.in_valid = 1'b1; bus_s.A = 18'sd1; bus_s.B = 18'sd1; bus_s.D = 18'sd0;
    bus_s.C = c[39:0]; bus_s.opmode = op;
    bus_w.in_valid = 1'b1; bus_w.A = 18'sd1; bus_w.B = 18'sd1; bus_w.D = 18'sd0;
    bus_w.C = c[39:0]; bus_w.opmode = op;
    idle(1, "sat_issue");
    bus_s.in_valid = 1'b0; bus_w.in_valid = 1'b0;
    idle(3, "sat_wait");
    checks++;
    if (bus_s.out_valid !== 1'b1 || bus_s.P !== es || bus_s.ovf !== exp_ovf) begin
      errors++;
      $display("FAIL %s_sat: got ov=%0b P=%0d ovf=%0b want 1/%0d/%0b",
               tag, bus_s.out_valid, bus_s.P, bus_s.ovf, es, exp_ovf);
    end
    checks++;
    if (bus_w.out_valid !== 1'b1 || bus_w.P !== ew || bus_w.ovf !== exp_ovf) begin
      errors++;
      $display("FAIL %s_wrap: got ov=%0b P=%0d ovf=%0b want 1/%0d/%0b",
               tag, bus_w.out_valid, bus_w.P, bus_w.ovf, ew, exp_ovf);
    end
  endtask

  task automatic test_saturate();
    longint lim;
    lim = longint'(1) <<< 39;
    run40(lim - 1, 4'b0000, lim - 1, -lim, 1'b1, "pos_ovf");
    run40(-lim, 4'b0010, -lim, lim - 1, 1'b1, "neg_ovf");
    run40(lim - 2, 4'b0000, lim - 1, lim - 1, 1'b0, "edge_fit");
  endtask

  task automatic test_random();
    longint a, b, d, c;
    bit ce_i, v, clr;
    bit [3:0] op;
    for (int i = 0; i < 400; i++) begin
      ce_i = ($urandom_range(0, 9) != 0);
      v    = ($urandom_range(0, 2) != 0);
      clr  = ($urandom_range(0, 15) == 0);
      op   = 4'($urandom);
      a = $signed(18'($urandom)); b = $signed(18'($urandom)); d = $signed(18'($urandom));
      if ($urandom_range(0, 7) == 0) c = 48'sh7FFF_FFFF_FFFF - longint'($urandom_range(0, 1000));
      else                           c = $signed(48'({$urandom(), $urandom()}));
      step(ce_i, v, a, b, d, c, op, clr, "random");
    end
  endtask

  task automatic test_reset_inflight();
    int stale;
    stale = 0;
    idle(4, "rst_settle");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 100 + i, 7, 1, 5, 4'b0000, 1'b0, "rst_issue");
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.P !== '0 || bus.out_valid !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_inflight: got P=%0d ov=%0b ovf=%0b want 0/0/0",
               bus.P, bus.out_valid, bus.ovf);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle(1, "rst_after");
      if (bus.out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL reset_stale_results: got %0d want 0", stale);
    end
  endtask

  initial begin
    bus.ce = 1'b1; bus.in_valid = 1'b0; bus.clr_acc = 1'b0; bus.opmode = 4'd0;
    bus.A = '0; bus.B = '0; bus.D = '0; bus.C = '0;
    bus_s.ce = 1'b1; bus_s.in_valid = 1'b0; bus_s.clr_acc = 1'b0; bus_s.opmode = 4'd0;
    bus_s.A = '0; bus_s.B = '0; bus_s.D = '0; bus_s.C = '0;
    bus_w.ce = 1'b1; bus_w.in_valid = 1'b0; bus_w.clr_acc = 1'b0; bus_w.opmode = 4'd0;
    bus_w.A = '0; bus_w.B = '0; bus_w.D = '0; bus_w.C = '0;
    model_reset();

    test_reset();
    test_basic();
    test_back_to_back();
    test_accumulate();
    test_ce_toggle();
    test_saturate();
    test_random();
    test_reset_inflight();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
